saradc_dig_lfsr_gen: RTL and testbench

SARADC_DIG_LFSR_GEN -- requirements
Module: saradc_dig_lfsr_gen

---
 rtl/saradc_dig_lfsr_pkg.sv | 33 +++
 rtl/saradc_dig_lfsr_step.sv | 18 +
 rtl/saradc_dig_lfsr_gen.sv | 136 +++++++++++++
 tb/tb_saradc_dig_lfsr_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/saradc_dig_lfsr_pkg.sv
// Shared definitions for the SAR-ADC digital LFSR generator: legal parameter
// limits and the maximal-length Fibonacci tap-mask table for WIDTH 3..16.
package saradc_dig_lfsr_pkg;

  localparam int unsigned LFSR_WIDTH_MIN = 3;
  localparam int unsigned LFSR_WIDTH_MAX = 16;
  localparam int unsigned LFSR_STEPS_MIN = 1;
  localparam int unsigned LFSR_MASK_W    = 16;

  // Bit i set means state bit i feeds the XOR feedback (tap i+1 of the polynomial).
  function automatic logic [LFSR_MASK_W-1:0] lfsr_tap_mask(input int unsigned width);
    logic [LFSR_MASK_W-1:0] mask;
    case (width)
      3:       mask = 16'h0006;  // x^3+x^2+1
      4:       mask = 16'h000C;  // x^4+x^3+1
      5:       mask = 16'h0014;  // x^5+x^3+1
      6:       mask = 16'h0030;  // x^6+x^5+1
      7:       mask = 16'h0060;  // x^7+x^6+1
      8:       mask = 16'h00B8;  // x^8+x^6+x^5+x^4+1
      9:       mask = 16'h0110;  // x^9+x^5+1
      10:      mask = 16'h0240;  // x^10+x^7+1
      11:      mask = 16'h0500;  // x^11+x^9+1
      12:      mask = 16'h0829;  // x^12+x^6+x^4+x+1
      13:      mask = 16'h100D;  // x^13+x^4+x^3+x+1
      14:      mask = 16'h2015;  // x^14+x^5+x^3+x+1
      15:      mask = 16'h6000;  // x^15+x^14+1
      16:      mask = 16'hD008;  // x^16+x^15+x^13+x^4+1
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/saradc_dig_lfsr_step.sv
// One combinational Fibonacci LFSR step (left shift, XOR feedback into bit 0).
module saradc_dig_lfsr_step
  import saradc_dig_lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_tap_mask(WIDTH));

  logic fb;

  assign fb  = ^(cur & TAPS);
  assign nxt = {cur[WIDTH-2:0], fb};

endmodule

// File: rtl/saradc_dig_lfsr_gen.sv
// SAR-ADC digital LFSR generator: STEPS advances per enabled cycle, seed load
// with zero-seed substitution. Wrap/period detection when
// SARADC_DIG_LFSR_WRAP_DET_EN is defined.
module saradc_dig_lfsr_gen
  import saradc_dig_lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH    = 6,
  parameter int unsigned      STEPS    = 1,
  parameter logic [WIDTH-1:0] SEED_RST = '1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] val_o,
  output logic             bit_o,
  output logic             lockup_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] period_o
);

  if ((WIDTH < LFSR_WIDTH_MIN) || (WIDTH > LFSR_WIDTH_MAX)) begin : g_bad_width
    $error("saradc_dig_lfsr_gen: WIDTH=%0d outside %0d..%0d", WIDTH, LFSR_WIDTH_MIN, LFSR_WIDTH_MAX);
  end
  if ((STEPS < LFSR_STEPS_MIN) || (STEPS > WIDTH)) begin : g_bad_steps
    $error("saradc_dig_lfsr_gen: STEPS=%0d outside %0d..WIDTH", STEPS, LFSR_STEPS_MIN);
  end
  if (SEED_RST == '0) begin : g_bad_seed
    $error("saradc_dig_lfsr_gen: SEED_RST must not be zero");
  end

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] seed_acc;
  logic [WIDTH-1:0] advanced;
  logic             seed_zero;
  logic             lockup_q;

  assign seed_zero = (seed_i == '0);
  assign seed_acc  = seed_zero ? '1 : seed_i;

  for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    if (gi == 0) begin : g_head
      assign cur = state_q;
    end else begin : g_link
      assign cur = g_step[gi-1].nxt;
    end
    saradc_dig_lfsr_step #(.WIDTH(WIDTH)) u_step (
      .cur (cur),
      .nxt (nxt)
    );
  end

  assign advanced = g_step[STEPS-1].nxt;

  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= SEED_RST;
      lockup_q <= 1'b0;
    end else if (load_i) begin
      state_q  <= seed_acc;
      lockup_q <= seed_zero;
    end else begin
      lockup_q <= 1'b0;
      if (enable_i) begin
        state_q <= advanced;
      end
    end
  end

  assign val_o    = state_q;
  assign bit_o    = state_q[WIDTH-1];
  assign lockup_o = lockup_q;

`ifdef SARADC_DIG_LFSR_WRAP_DET_EN
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] per_q;
  logic             wrap_q;

  // Counter/period ripple through the step chain; a match restarts the count
  // so later steps in the same cycle are counted from the wrap point.
  for (genvar gi = 0; gi < STEPS; gi++) begin : g_wrap
    logic [WIDTH-1:0] cnt_in;
    logic [WIDTH-1:0] per_in;
    logic             hit_in;
    logic [WIDTH-1:0] cnt_inc;
    logic             match;
    logic [WIDTH-1:0] cnt_out;
    logic [WIDTH-1:0] per_out;
    logic             hit_out;
    if (gi == 0) begin : g_head
      assign cnt_in = cnt_q;
      assign per_in = per_q;
      assign hit_in = 1'b0;
    end else begin : g_link
      assign cnt_in = g_wrap[gi-1].cnt_out;
      assign per_in = g_wrap[gi-1].per_out;
      assign hit_in = g_wrap[gi-1].hit_out;
    end
    assign cnt_inc = cnt_in + WIDTH'(1);
    assign match   = (g_step[gi].nxt == ref_q);
    assign cnt_out = match ? '0 : cnt_inc;
    assign per_out = match ? cnt_inc : per_in;
    assign hit_out = hit_in | match;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      ref_q  <= SEED_RST;
      cnt_q  <= '0;
      per_q  <= '0;
      wrap_q <= 1'b0;
    end else if (load_i) begin
      ref_q  <= seed_acc;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else if (enable_i) begin
      cnt_q  <= g_wrap[STEPS-1].cnt_out;
      per_q  <= g_wrap[STEPS-1].per_out;
      wrap_q <= g_wrap[STEPS-1].hit_out;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign wrap_o   = wrap_q;
  assign period_o = per_q;
`else
  assign wrap_o   = 1'b0;
  assign period_o = '0;
`endif

endmodule

// File: tb/tb_saradc_dig_lfsr_gen.sv
// Scoreboard bench for saradc_dig_lfsr_gen: two WIDTH=6 instances (STEPS 1 and 2)
// under directed and random stimulus, plus a WIDTH 3..16 free-running sweep.
`timescale 1ns/1ps
module tb_saradc_dig_lfsr_gen;

  localparam int unsigned SWEEP_CYC = 8200;
`ifdef SARADC_DIG_LFSR_WRAP_DET_EN
  localparam bit WDET = 1'b1;
`else
  localparam bit WDET = 1'b0;
`endif

  typedef struct {
    int unsigned st;
    int unsigned rf;
    int unsigned cnt;
    int unsigned per;
    bit          lk;
    bit          wr;
  } mdl_t;

  typedef struct {
    mdl_t a;
    mdl_t b;
  } exp_t;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic       clk      = 1'b0;
  logic       res      = 1'b1;
  logic       load_i   = 1'b0;
  logic       enable_i = 1'b0;
  logic [5:0] seed_i   = '0;
  logic       sw_res   = 1'b1;
  logic       sw_en    = 1'b0;
  bit         sw_start = 1'b0;

  logic [5:0] val1, per1, val2, per2;
  logic       bit1, lk1, wr1, bit2, lk2, wr2;

  exp_t exp_q[$];
  mdl_t m1, m2;

  logic [5:0] tbl1 [7] = '{6'h3F, 6'h3E, 6'h3C, 6'h38, 6'h30, 6'h20, 6'h01};
  logic [5:0] tbl2 [4] = '{6'h3F, 6'h3C, 6'h30, 6'h01};

  always #5 clk = ~clk;

  saradc_dig_lfsr_gen #(.WIDTH(6), .STEPS(1)) u_dut1 (
    .clk(clk), .res(res), .enable_i(enable_i), .load_i(load_i), .seed_i(seed_i),
    .val_o(val1), .bit_o(bit1), .lockup_o(lk1), .wrap_o(wr1), .period_o(per1)
  );

  saradc_dig_lfsr_gen #(.WIDTH(6), .STEPS(2)) u_dut2 (
    .clk(clk), .res(res), .enable_i(enable_i), .load_i(load_i), .seed_i(seed_i),
    .val_o(val2), .bit_o(bit2), .lockup_o(lk2), .wrap_o(wr2), .period_o(per2)
  );

  // Feedback taps listed as polynomial exponents (x^t terms besides x^0).
  function automatic int unsigned poly_next(input int unsigned w, input int unsigned s);
    int unsigned t [4];
    int unsigned fb;
    case (w)
      3:  t = '{3, 2, 0, 0};
      4:  t = '{4, 3, 0, 0};
      5:  t = '{5, 3, 0, 0};
      6:  t = '{6, 5, 0, 0};
      7:  t = '{7, 6, 0, 0};
      8:  t = '{8, 6, 5, 4};
      9:  t = '{9, 5, 0, 0};
      10: t = '{10, 7, 0, 0};
      11: t = '{11, 9, 0, 0};
      12: t = '{12, 6, 4, 1};
      13: t = '{13, 4, 3, 1};
      14: t = '{14, 5, 3, 1};
      15: t = '{15, 14, 0, 0};
      16: t = '{16, 15, 13, 4};
      default: t = '{0, 0, 0, 0};
    endcase
    fb = 0;
    foreach (t[i]) if (t[i] != 0) fb = fb ^ ((s >> (t[i] - 1)) & 1);
    return ((s << 1) | fb) & ((32'd1 << w) - 1);
  endfunction

  function automatic mdl_t mdl_cycle(input mdl_t m_in, input int unsigned w, input int unsigned steps,
                                     input bit r, input bit l, input bit e, input int unsigned seed);
    mdl_t m;
    int unsigned ones;
    m = m_in;
    ones = (32'd1 << w) - 1;
    m.lk = 1'b0;
    m.wr = 1'b0;
    if (r) begin
      m.st = ones; m.rf = ones; m.cnt = 0; m.per = 0;
    end else if (l) begin
      m.st  = (seed == 0) ? ones : seed;
      m.lk  = (seed == 0);
      m.rf  = m.st;
      m.cnt = 0;
    end else if (e) begin
      for (int unsigned k = 0; k < steps; k++) begin
        m.st  = poly_next(w, m.st);
        m.cnt = m.cnt + 1;
        if (m.st == m.rf) begin
          m.wr = 1'b1; m.per = m.cnt; m.cnt = 0;
        end
      end
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input mdl_t m, input int unsigned w, input logic [31:0] v,
                         input logic b, input logic lk, input logic wr, input logic [31:0] per);
    chk({tag, "_val"}, v, m.st);
    chk({tag, "_bit"}, {31'b0, b}, (m.st >> (w - 1)) & 1);
    chk({tag, "_lockup"}, {31'b0, lk}, {31'b0, m.lk});
    chk({tag, "_wrap"}, {31'b0, wr}, {31'b0, WDET & m.wr});
    chk({tag, "_period"}, per, WDET ? m.per : 32'd0);
  endtask

  task automatic drive(input bit r, input bit l, input bit e, input logic [5:0] sd);
    exp_t x;
    @(negedge clk);
    res = r; load_i = l; enable_i = e; seed_i = sd;
    m1 = mdl_cycle(m1, 6, 1, r, l, e, 32'(sd));
    m2 = mdl_cycle(m2, 6, 2, r, l, e, 32'(sd));
    x.a = m1;
    x.b = m2;
    exp_q.push_back(x);
  endtask

  always @(posedge clk) begin : monitor
    exp_t x;
    #1;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      chk_out("dut1", x.a, 6, 32'(val1), bit1, lk1, wr1, 32'(per1));
      chk_out("dut2", x.b, 6, 32'(val2), bit2, lk2, wr2, 32'(per2));
    end
  end

  for (genvar gw = 3; gw <= 16; gw++) begin : g_sweep
    localparam int unsigned SW = (gw >= 14) ? gw : 1;
    logic [gw-1:0] v, per;
    logic          b, lk, wr;

    saradc_dig_lfsr_gen #(.WIDTH(gw), .STEPS(SW)) u_dut (
      .clk(clk), .res(sw_res), .enable_i(sw_en), .load_i(1'b0), .seed_i('0),
      .val_o(v), .bit_o(b), .lockup_o(lk), .wrap_o(wr), .period_o(per)
    );

    initial begin : run
      mdl_t m;
      int unsigned ones, dut_ret, mdl_ret;
      bit zero_seen;
      string tag;
      ones = (32'd1 << gw) - 1;
      m = '{st: ones, rf: ones, cnt: 0, per: 0, lk: 1'b0, wr: 1'b0};
      dut_ret = 0; mdl_ret = 0; zero_seen = 1'b0;
      tag = $sformatf("sweep_w%0d", gw);
      wait (sw_start);
      for (int unsigned c = 1; c <= SWEEP_CYC; c++) begin
        @(posedge clk);
        #1;
        m = mdl_cycle(m, gw, SW, 1'b0, 1'b0, 1'b1, 0);
        chk_out(tag, m, gw, 32'(v), b, lk, wr, 32'(per));
        if (v == '0) zero_seen = 1'b1;
        if (dut_ret == 0 && 32'(v) == ones) dut_ret = c;
        if (mdl_ret == 0 && m.st == ones) mdl_ret = c;
      end
      chk({tag, "_zero_state"}, {31'b0, zero_seen}, 32'd0);
      chk({tag, "_first_return"}, dut_ret, (SW == 1) ? ones : mdl_ret);
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    m1 = '{st: 32'h3F, rf: 32'h3F, cnt: 0, per: 0, lk: 1'b0, wr: 1'b0};
    m2 = m1;

    drive(1, 0, 0, 6'h00);
    drive(1, 0, 0, 6'h00);
    @(posedge clk); #2;
    chk("req031_reset", 32'(val1), 32'(tbl1[0]));
    chk("req032_reset", 32'(val2), 32'(tbl2[0]));
    for (int i = 1; i <= 6; i++) begin
      drive(0, 0, 1, 6'h00);
      @(posedge clk); #2;
      chk("req031_seq", 32'(val1), 32'(tbl1[i]));
      if (i <= 3) chk("req032_seq", 32'(val2), 32'(tbl2[i]));
    end

    drive(0, 1, 1, 6'h00);
    @(posedge clk); #2;
    chk("req033_val", 32'(val1), 32'h3F);
    chk("req033_lockup", {31'b0, lk1}, 32'd1);
    drive(0, 0, 0, 6'h00);
    @(posedge clk); #2;
    chk("req033_pulse_end", {31'b0, lk1}, 32'd0);

    drive(0, 1, 1, 6'h15);
    @(posedge clk); #2;
    chk("load_no_advance", 32'(val2), 32'h15);

    repeat (300) begin
      bit r, l, e;
      logic [5:0] sd;
      r  = ($urandom_range(0, 63) == 0);
      l  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      sd = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom);
      drive(r, l, e, sd);
    end

    drive(1, 0, 0, 6'h00);
    repeat (63) drive(0, 0, 1, 6'h00);
    @(posedge clk); #2;
    chk("req034_val", 32'(val1), 32'h3F);
    chk("req034_wrap", {31'b0, wr1}, WDET ? 32'd1 : 32'd0);
    chk("req034_period", 32'(per1), WDET ? 32'd63 : 32'd0);
    drive(0, 0, 0, 6'h00);
    @(posedge clk); #2;
    chk("req034_wrap_end", {31'b0, wr1}, 32'd0);
    chk("req034_period_hold", 32'(per1), WDET ? 32'd63 : 32'd0);

    repeat (5) drive(0, 0, 1, 6'h00);
    drive(1, 1, 1, 6'd15);
    @(posedge clk); #2;
    chk("req035_val", 32'(val1), 32'h3F);
    chk("req035_lockup", {31'b0, lk1}, 32'd0);
    chk("req035_wrap", {31'b0, wr1}, 32'd0);
    chk("req035_period", 32'(per1), 32'd0);
    drive(0, 0, 0, 6'h00);

    @(negedge clk);
    sw_res   = 1'b0;
    sw_en    = 1'b1;
    sw_start = 1'b1;
    repeat (SWEEP_CYC) @(negedge clk);
    sw_en = 1'b0;
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
